oled_page_streamer: RTL and testbench

OLED_PAGE_STREAMER -- requirements
Module: oled_page_streamer

---
 rtl/oled_page_streamer_if.sv | 35 +++
 rtl/oled_page_streamer.sv | 181 ++++++++++++++++++
 tb/tb_oled_page_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_page_streamer_if.sv
// Host, pixel-buffer and SPI byte-engine signals of the OLED page streamer.
// master is the streamer side; slave is the environment side.
interface oled_page_streamer_if #(
    parameter int unsigned COLS  = 128,
    parameter int unsigned PAGES = 4
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned AW = PW + CW;

    logic          update_start;
    logic [PW-1:0] first_page;
    logic [PW-1:0] last_page;
    logic [1:0]    mode;
    logic [7:0]    fill_pattern;
    logic          update_ready;
    logic          busy;
    logic          err;
    logic [AW-1:0] pbuf_addr;
    logic [7:0]    pbuf_data;
    logic          spi_start;
    logic [7:0]    spi_data;
    logic          spi_dc;
    logic          spi_done;

    modport master (
        input  update_start, first_page, last_page, mode, fill_pattern, pbuf_data, spi_done,
        output update_ready, busy, err, pbuf_addr, spi_start, spi_data, spi_dc
    );

    modport slave (
        output update_start, first_page, last_page, mode, fill_pattern, pbuf_data, spi_done,
        input  update_ready, busy, err, pbuf_addr, spi_start, spi_data, spi_dc
    );
endinterface

// File: rtl/oled_page_streamer.sv
// Streams a window of display pages to an SPI byte engine: per page three
// addressing commands, then COLS data bytes taken from the buffer or synthesized.
module oled_page_streamer #(
    parameter int unsigned COLS  = 128,
    parameter int unsigned PAGES = 4
) (
    input logic                  clk,
    input logic                  rst,
    oled_page_streamer_if.master bus
);
    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned PW  = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned AW  = PW + CW;
    localparam int unsigned PLW = PW + 1;
    localparam logic [CW-1:0]  COL_LAST   = CW'(COLS - 1);
    localparam logic [PLW-1:0] PAGE_LIMIT = PLW'(PAGES);
    localparam logic [1:0]     DATA_PHASE = 2'd3;

    typedef enum logic [2:0] {IDLE, CMD, FETCH, SEND, SPI_WAIT, DONE} state_t;

    state_t        state, state_d;
    logic [PW-1:0] page, page_d;
    logic [PW-1:0] last_q, last_d;
    logic [CW-1:0] col, col_d;
    logic [1:0]    cmd_idx, cmd_idx_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    fill_q, fill_d;

    logic          spi_start_d;
    logic [7:0]    spi_data_d;
    logic          spi_dc_d;
    logic          busy_d;
    logic          err_d;
    logic [AW-1:0] pbuf_addr_d;

    logic          window_ok;
    logic          col_wrap;
    logic          page_final;
    logic [7:0]    cmd_byte;
    logic [7:0]    data_byte;

    // Widened compare so last_page >= PAGES is caught even when PAGES is a power of two.
    assign window_ok  = (bus.first_page <= bus.last_page) &&
                        ({1'b0, bus.last_page} < PAGE_LIMIT);
    assign col_wrap   = (col == COL_LAST);
    assign page_final = (page == last_q);

    assign bus.update_ready = (state == IDLE) && !bus.update_start;

    // Page-address command, then lower and upper column-start commands.
    always_comb begin
        unique case (cmd_idx)
            2'd0:    cmd_byte = 8'hB0 | 8'(page);
            2'd1:    cmd_byte = 8'h00;
            default: cmd_byte = 8'h10;
        endcase
    end

    always_comb begin
        unique case (mode_q)
            2'b00:   data_byte = bus.pbuf_data;
            2'b01:   data_byte = 8'h00;
            2'b10:   data_byte = fill_q;
            default: data_byte = ~bus.pbuf_data;
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state;
        page_d      = page;
        last_d      = last_q;
        col_d       = col;
        cmd_idx_d   = cmd_idx;
        mode_d      = mode_q;
        fill_d      = fill_q;
        spi_start_d = 1'b0;
        spi_data_d  = bus.spi_data;
        spi_dc_d    = bus.spi_dc;
        busy_d      = bus.busy;
        err_d       = 1'b0;
        pbuf_addr_d = bus.pbuf_addr;

        unique case (state)
            IDLE: begin
                if (bus.update_start) begin
                    if (window_ok) begin
                        state_d   = CMD;
                        page_d    = bus.first_page;
                        last_d    = bus.last_page;
                        mode_d    = bus.mode;
                        fill_d    = bus.fill_pattern;
                        col_d     = '0;
                        cmd_idx_d = '0;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            CMD:   state_d = SEND;
            FETCH: state_d = SEND;
            SEND: begin
                state_d     = SPI_WAIT;
                spi_start_d = 1'b1;
                if (cmd_idx == DATA_PHASE) begin
                    spi_data_d = data_byte;
                    spi_dc_d   = 1'b1;
                end else begin
                    spi_data_d = cmd_byte;
                    spi_dc_d   = 1'b0;
                end
            end
            SPI_WAIT: begin
                if (bus.spi_done) begin
                    if (cmd_idx != DATA_PHASE) begin
                        cmd_idx_d = cmd_idx + 2'd1;
                        if (cmd_idx == 2'd2) begin
                            state_d     = FETCH;
                            pbuf_addr_d = {page, col};
                        end else begin
                            state_d = CMD;
                        end
                    end else if (col_wrap) begin
                        col_d = '0;
                        if (page_final) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                        end else begin
                            page_d    = page + 1'b1;
                            cmd_idx_d = '0;
                            state_d   = CMD;
                        end
                    end else begin
                        col_d       = CW'(col + 1'b1);
                        state_d     = FETCH;
                        pbuf_addr_d = {page, CW'(col + 1'b1)};
                    end
                end
            end
            DONE: begin
                // A held request must drop before another update can be accepted.
                if (!bus.update_start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            page          <= '0;
            last_q        <= '0;
            col           <= '0;
            cmd_idx       <= '0;
            mode_q        <= '0;
            fill_q        <= '0;
            bus.spi_start <= 1'b0;
            bus.spi_data  <= 8'h00;
            bus.spi_dc    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
            bus.pbuf_addr <= '0;
        end else begin
            state         <= state_d;
            page          <= page_d;
            last_q        <= last_d;
            col           <= col_d;
            cmd_idx       <= cmd_idx_d;
            mode_q        <= mode_d;
            fill_q        <= fill_d;
            bus.spi_start <= spi_start_d;
            bus.spi_data  <= spi_data_d;
            bus.spi_dc    <= spi_dc_d;
            bus.busy      <= busy_d;
            bus.err       <= err_d;
            bus.pbuf_addr <= pbuf_addr_d;
        end
    end
endmodule

// File: tb/tb_oled_page_streamer.sv
// Bench for oled_page_streamer: two configurations (128x4 and 16x8) against a
// byte-stream model built from the buffer contents, window and mode.
module tb_oled_page_streamer;
    localparam int unsigned CA = 128, PA = 4, PWA = 2;
    localparam int unsigned CB = 16,  PB = 8, PWB = 3;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    oled_page_streamer_if #(.COLS(CA), .PAGES(PA)) ia ();
    oled_page_streamer_if #(.COLS(CB), .PAGES(PB)) ib ();

    oled_page_streamer #(.COLS(CA), .PAGES(PA)) u_a (.clk(clk), .rst(rst), .bus(ia));
    oled_page_streamer #(.COLS(CB), .PAGES(PB)) u_b (.clk(clk), .rst(rst), .bus(ib));

    logic [7:0] mem_a [512];
    logic [7:0] mem_b [128];
    logic [8:0] exp_a [$];
    logic [8:0] exp_b [$];
    int         bytes_a = 0, bytes_b = 0, errs_a = 0, errs_b = 0;
    int         cnt_a = 0, cnt_b = 0;
    int         prev_a = 0, prev_b = 0;
    bit         spur_a = 1'b0;
    bit         hold_a = 1'b0, hold_b = 1'b0;
    logic [8:0] held_a, held_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Expected byte stream: {dc, byte} for every transfer of the window.
    task automatic push(input int w, input logic [8:0] v);
        if (w == 0) exp_a.push_back(v);
        else        exp_b.push_back(v);
    endtask

    task automatic build(input int w, input int f, input int l, input int m, input logic [7:0] fill);
        int cols, pages;
        logic [7:0] b, d;
        cols  = (w == 0) ? CA : CB;
        pages = (w == 0) ? PA : PB;
        if (f > l || l >= pages) return;
        for (int p = f; p <= l; p++) begin
            push(w, {1'b0, 8'hB0 | 8'(p)});
            push(w, 9'h000);
            push(w, 9'h010);
            for (int c = 0; c < cols; c++) begin
                if (w == 0) b = mem_a[p * cols + c];
                else        b = mem_b[p * cols + c];
                case (m)
                    0:       d = b;
                    1:       d = 8'h00;
                    2:       d = fill;
                    default: d = ~b;
                endcase
                push(w, {1'b1, d});
            end
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 0) ? ia.busy : ib.busy;
    endfunction
    function automatic logic ready_of(input int w);
        return (w == 0) ? ia.update_ready : ib.update_ready;
    endfunction
    function automatic int bytes_of(input int w);
        return (w == 0) ? bytes_a : bytes_b;
    endfunction
    function automatic int errs_of(input int w);
        return (w == 0) ? errs_a : errs_b;
    endfunction
    function automatic int qsize(input int w);
        return (w == 0) ? exp_a.size() : exp_b.size();
    endfunction

    task automatic set_in(input int w, input bit s, input int f, input int l, input int m, input int fill);
        if (w == 0) begin
            ia.update_start = s;
            ia.first_page   = PWA'(f);
            ia.last_page    = PWA'(l);
            ia.mode         = 2'(m);
            ia.fill_pattern = 8'(fill);
        end else begin
            ib.update_start = s;
            ib.first_page   = PWB'(f);
            ib.last_page    = PWB'(l);
            ib.mode         = 2'(m);
            ib.fill_pattern = 8'(fill);
        end
    endtask

    // Pixel buffers answer one cycle after the address is presented.
    always @(posedge clk) begin
        #1;
        ia.pbuf_data = mem_a[prev_a];
        prev_a       = int'(ia.pbuf_addr);
        ib.pbuf_data = mem_b[prev_b];
        prev_b       = int'(ib.pbuf_addr);
    end

    // SPI engines: fixed 5-cycle ack for the large config, random 1..6 for the small one.
    always @(posedge clk) begin
        #1;
        ia.spi_done = 1'b0;
        ib.spi_done = 1'b0;
        if (rst) begin
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (ia.spi_start) cnt_a = 5;
            else if (cnt_a > 0) begin
                cnt_a--;
                if (cnt_a == 0) ia.spi_done = 1'b1;
            end else if (spur_a && !ia.busy && $urandom_range(0, 2) == 0) ia.spi_done = 1'b1;
            if (ib.spi_start) cnt_b = $urandom_range(1, 6);
            else if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) ib.spi_done = 1'b1;
            end
        end
    end

    // Per-cycle comparison of both streamers against the expected streams.
    always @(negedge clk) begin
        if (rst) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            if (ia.spi_start) begin
                bytes_a++;
                check("a_start_busy", ia.busy, 1);
                check("a_start_overlap", hold_a, 0);
                if (exp_a.size() == 0) check("a_unexpected_start", ia.spi_start, 0);
                else check("a_byte", {ia.spi_dc, ia.spi_data}, exp_a.pop_front());
                held_a = {ia.spi_dc, ia.spi_data};
                hold_a = 1'b1;
            end else if (hold_a) check("a_hold", {ia.spi_dc, ia.spi_data}, held_a);
            if (ia.spi_done) hold_a = 1'b0;
            if (ia.err) errs_a++;
            if (ia.update_start) check("a_ready_vs_start", ia.update_ready, 0);

            if (ib.spi_start) begin
                bytes_b++;
                check("b_start_busy", ib.busy, 1);
                check("b_start_overlap", hold_b, 0);
                if (exp_b.size() == 0) check("b_unexpected_start", ib.spi_start, 0);
                else check("b_byte", {ib.spi_dc, ib.spi_data}, exp_b.pop_front());
                held_b = {ib.spi_dc, ib.spi_data};
                hold_b = 1'b1;
            end else if (hold_b) check("b_hold", {ib.spi_dc, ib.spi_data}, held_b);
            if (ib.spi_done) hold_b = 1'b0;
            if (ib.err) errs_b++;
            if (ib.update_start) check("b_ready_vs_start", ib.update_ready, 0);
        end
    end

    task automatic do_update(input int w, input int f, input int l, input int m,
                             input logic [7:0] fill, input bit hold, output int nbytes);
        int  cols, pages, want_bytes, b0, e0;
        bit  valid, seen;
        cols       = (w == 0) ? CA : CB;
        pages      = (w == 0) ? PA : PB;
        valid      = (f <= l) && (l < pages);
        want_bytes = valid ? (l - f + 1) * (3 + cols) : 0;
        build(w, f, l, m, fill);
        b0 = bytes_of(w);
        e0 = errs_of(w);
        @(negedge clk);
        set_in(w, 1, f, l, m, fill);
        if (valid) begin
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = busy_of(w);
            end
            check("busy_rise", seen, 1);
            if (!hold) begin
                @(negedge clk);
                set_in(w, 0, $urandom, $urandom, $urandom, $urandom);
            end
            seen = 1'b0;
            for (int i = 0; i < 40000 && !seen; i++) begin
                @(negedge clk);
                seen = !busy_of(w);
            end
            check("busy_fall", seen, 1);
        end else begin
            repeat (4) @(negedge clk);
        end
        if (hold || !valid) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check("no_retrigger", busy_of(w), 0);
            end
        end
        set_in(w, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = ready_of(w);
        end
        check("ready_after_drop", seen, 1);
        nbytes = bytes_of(w) - b0;
        check("byte_count", nbytes, want_bytes);
        check("err_cycles", errs_of(w) - e0, valid ? 0 : 1);
        check("stream_drained", qsize(w), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, cnt;
        bit  hit;
        set_in(0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0);
        ia.spi_done = 1'b0;
        ib.spi_done = 1'b0;
        ia.pbuf_data = 8'h00;
        ib.pbuf_data = 8'h00;
        for (int i = 0; i < 512; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_spi_start", ia.spi_start, 0);
        check("rst_spi_data", ia.spi_data, 8'h00);
        check("rst_spi_dc", ia.spi_dc, 0);
        check("rst_pbuf_addr", ia.pbuf_addr, 0);
        check("rst_busy", ia.busy, 0);
        check("rst_err", ia.err, 0);
        check("rst_ready", ia.update_ready, 1);
        check("rst_b_busy", ib.busy, 0);

        // Pin the model with hand-computed values.
        build(1, 6, 7, 2, 8'hA5);
        check("model_b_len", exp_b.size(), 38);
        check("model_b_cmd6", exp_b[0], 9'h0B6);
        check("model_b_col", exp_b[2], 9'h010);
        check("model_b_fill", exp_b[3], 9'h1A5);
        check("model_b_cmd7", exp_b[19], 9'h0B7);
        exp_b.delete();

        do_update(0, 0, 3, 0, 8'h00, 1'b0, n);
        check("a_full_window_bytes", n, 524);

        for (int c = 0; c < 128; c++) mem_a[256 + c] = 8'h0F;
        build(0, 2, 2, 3, 8'h00);
        check("model_a_len", exp_a.size(), 131);
        check("model_a_inv", exp_a[3], 9'h1F0);
        exp_a.delete();
        do_update(0, 2, 2, 3, 8'h00, 1'b1, n);
        check("a_inverted_page_bytes", n, 131);

        do_update(0, 3, 1, 0, 8'h00, 1'b1, n);
        check("a_bad_window_bytes", n, 0);

        do_update(1, 6, 7, 2, 8'hA5, 1'b0, n);
        check("b_fill_bytes", n, 38);

        spur_a = 1'b1;
        repeat (20) @(negedge clk);
        check("spurious_idle_busy", ia.busy, 0);
        do_update(0, 1, 1, 1, 8'h00, 1'b1, n);
        check("a_clear_bytes", n, 131);
        repeat (20) @(negedge clk);
        spur_a = 1'b0;

        // Reset during the 40th data byte, then a fresh update.
        for (int i = 0; i < 512; i++) mem_a[i] = 8'($urandom);
        build(0, 0, 3, 0, 8'h00);
        @(negedge clk);
        set_in(0, 1, 0, 3, 0, 0);
        cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (ia.spi_start && ia.spi_dc) begin
                cnt++;
                if (cnt == 40) hit = 1'b1;
            end
        end
        check("rst_reached_40th", hit, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_spi_start", ia.spi_start, 0);
        check("mid_rst_spi_data", ia.spi_data, 8'h00);
        check("mid_rst_spi_dc", ia.spi_dc, 0);
        check("mid_rst_pbuf_addr", ia.pbuf_addr, 0);
        check("mid_rst_busy", ia.busy, 0);
        check("mid_rst_err", ia.err, 0);
        exp_a.delete();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_idle", ia.busy, 0);
        end
        do_update(0, 1, 2, 2, 8'($urandom), 1'b0, n);
        check("a_after_rst_bytes", n, 262);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
            do_update(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                      8'($urandom), 1'($urandom), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
